// File: rtl/exec_sequencer_pkg.sv
// Shared types and instruction field positions for the execute sequencer.
// Field offsets are relative to DW so that the layout scales with the datapath:
//   op  = [DW+3:DW+2], rd = [DW+1:DW], imm = [DW-1:0],
//   rs1 = [DW-1:DW-2], rs2 = [DW-3:DW-4].
package exec_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_MOVI = 2'b00,
    OP_ADD  = 2'b01,
    OP_AND  = 2'b10,
    OP_MVN  = 2'b11
  } opcode_t;

  localparam int OPW     = 2;
  localparam int REGW    = 2;
  localparam int OP_OFS  = 2;  // op  lsb = DW + OP_OFS
  localparam int RD_OFS  = 0;  // rd  lsb = DW + RD_OFS
  localparam int RS1_OFS = 2;  // rs1 lsb = DW - RS1_OFS
  localparam int RS2_OFS = 4;  // rs2 lsb = DW - RS2_OFS

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction handshake plus register-file port bundle.
// master: the sequencer side; slave: instruction source / register file side.
interface exec_sequencer_if #(parameter int DW = 8);
  logic [DW+3:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          rf_we;
  logic [1:0]    rf_selA;
  logic [1:0]    rf_selB;
  logic [DW-1:0] rf_dataW;
  logic [DW-1:0] rf_dataA;
  logic [DW-1:0] rf_dataB;
  logic          done;
  logic [2:0]    status;

  modport master (
    input  instr, instr_valid, rf_dataA, rf_dataB,
    output instr_ready, rf_we, rf_selA, rf_selB, rf_dataW, done, status
  );

  modport slave (
    output instr, instr_valid, rf_dataA, rf_dataB,
    input  instr_ready, rf_we, rf_selA, rf_selB, rf_dataW, done, status
  );
endinterface

// File: rtl/exec_sequencer_alu.sv
// Combinational ALU for the execute sequencer: ADD / AND / MVN plus N, Z, V.
module exec_alu
  import exec_seq_pkg::*;
#(
  parameter int DW = 8
) (
  input  opcode_t       opcode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          n,
  output logic          z,
  output logic          v
);

  // Result and signed-overflow select; MOVI never reaches the ALU path.
  always_comb begin
    result = '0;
    v      = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = a + b;
        v      = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      OP_AND:  result = a & b;
      OP_MVN:  result = ~a;
      default: result = '0;
    endcase
  end

  assign n = result[DW-1];
  assign z = (result == '0);

endmodule

// File: rtl/exec_sequencer.sv
// Multicycle execute sequencer driving a 4x8 register file.
// Port-A select doubles as the write address, so it carries rs1 in READ and
// rd otherwise. Optional status flags: define EXEC_SEQUENCER_STATUS_EN.
//
// state | meaning
// IDLE  | ready for an instruction; MOVI loads C directly
// READ  | selA=rs1, selB=rs2; operands captured into A/B
// EXEC  | C <= ALU(A,B); flags updated
// WB    | write C to rd, pulse done
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int DW        = 8,
  parameter int NREG_LOG2 = 2
) (
  input logic             clk,
  input logic             rst,
  exec_sequencer_if.master bus
);

  state_t                 state_q, state_d;
  logic [DW+3:0]          ir_q;
  logic [DW-1:0]          a_q, b_q, c_q;
  opcode_t                ir_op, in_op;
  logic [NREG_LOG2-1:0]   ir_rd, ir_rs1, ir_rs2;
  logic [DW-1:0]          alu_res;
  logic                   alu_n, alu_z, alu_v;
  logic                   ready, we, dn;
  logic [NREG_LOG2-1:0]   sel_a, sel_b;

  assign ir_op  = opcode_t'(ir_q[DW+OP_OFS +: OPW]);
  assign in_op  = opcode_t'(bus.instr[DW+OP_OFS +: OPW]);
  assign ir_rd  = ir_q[DW+RD_OFS +: REGW];
  assign ir_rs1 = ir_q[DW-RS1_OFS +: REGW];
  assign ir_rs2 = ir_q[DW-RS2_OFS +: REGW];

  exec_alu #(.DW(DW)) u_alu (
    .opcode (ir_op),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res),
    .n      (alu_n),
    .z      (alu_z),
    .v      (alu_v)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    we      = 1'b0;
    dn      = 1'b0;
    sel_a   = ir_rd;
    sel_b   = ir_rs2;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) state_d = (in_op == OP_MOVI) ? WB : READ;
      end
      READ: begin
        sel_a   = ir_rs1;
        state_d = EXEC;
      end
      EXEC: state_d = WB;
      WB: begin
        we      = 1'b1;
        dn      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Instruction, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.instr_valid) begin
          ir_q <= bus.instr;
          if (in_op == OP_MOVI) c_q <= bus.instr[DW-1:0];
        end
        READ: begin
          a_q <= bus.rf_dataA;
          b_q <= bus.rf_dataB;
        end
        EXEC:    c_q <= alu_res;
        default: ;
      endcase
    end
  end

`ifdef EXEC_SEQUENCER_STATUS_EN
  logic [2:0] status_q;

  // Flags change only on ALU ops, at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst)                  status_q <= 3'b000;
    else if (state_q == EXEC) status_q <= {alu_n, alu_z, alu_v};
  end

  assign bus.status = status_q;
`else
  wire unused_flags = ^{alu_n, alu_z, alu_v};
  assign bus.status = 3'b000;
`endif

  assign bus.instr_ready = ready;
  assign bus.rf_we       = we;
  assign bus.done        = dn;
  assign bus.rf_selA     = sel_a;
  assign bus.rf_selB     = sel_b;
  assign bus.rf_dataW    = c_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a register-file model and a
// write-back scoreboard.
module tb_exec_sequencer;

`ifdef EXEC_SEQUENCER_STATUS_EN
  localparam bit ST_EN = 1'b1;
`else
  localparam bit ST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_sequencer_if #(.DW(8)) bus ();

  exec_sequencer #(.DW(8), .NREG_LOG2(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] rf [4];
  assign bus.rf_dataA = rf[bus.rf_selA];
  assign bus.rf_dataB = rf[bus.rf_selB];
  always @(posedge clk) if (bus.rf_we) rf[bus.rf_selA] <= bus.rf_dataW;

  typedef struct {
    logic [1:0] rd;
    logic [7:0] data;
    logic [2:0] st;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mreg [4];
  logic [2:0] mst;
  int checks = 0;
  int errors = 0;
  int acc_seen = 0;
  int acc_exp = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] mk(input logic [1:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 4'h0};
  endfunction

  function automatic logic [11:0] movi(input logic [1:0] rd, input logic [7:0] imm);
    return {2'b00, rd, imm};
  endfunction

  // Reference model: compute the expected write and flags, in program order.
  task automatic model_push(input logic [11:0] w);
    logic [1:0] op, rd, r1, r2;
    logic [7:0] x, y, d;
    logic       v;
    exp_t       e;
    op = w[11:10]; rd = w[9:8]; r1 = w[7:6]; r2 = w[5:4];
    x = mreg[r1]; y = mreg[r2];
    v = 1'b0;
    case (op)
      2'b00: d = w[7:0];
      2'b01: begin
        d = x + y;
        v = (x[7] == y[7]) && (d[7] != x[7]);
      end
      2'b10: d = x & y;
      default: d = ~x;
    endcase
    if (op != 2'b00) mst = ST_EN ? {d[7], (d == 8'h00), v} : 3'b000;
    mreg[rd] = d;
    e.rd = rd; e.data = d; e.st = mst;
    sb.push_back(e);
  endtask

  // Present an instruction and return just after the accepting edge.
  task automatic send(input logic [11:0] w, input bit hold, input bit push);
    int n;
    if (push) model_push(w);
    acc_exp++;
    bus.instr = w;
    bus.instr_valid = 1'b1;
    n = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout observed=%0d expected=<20", n);
    end
    @(posedge clk);
    #1;
    if (!hold) bus.instr_valid = 1'b0;
  endtask

  always @(posedge clk)
    if (!rst && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) acc_seen++;

  // Scoreboard: every done pulse must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_wb observed=sel%0d/%0h expected=none", bus.rf_selA, bus.rf_dataW);
      end else begin
        e = sb.pop_front();
        chk("sb_rd",   16'(bus.rf_selA),  16'(e.rd));
        chk("sb_data", 16'(bus.rf_dataW), 16'(e.data));
        chk("sb_we",   16'(bus.rf_we),    16'd1);
        chk("sb_st",   16'(bus.status),   16'(e.st));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rf[i] = 8'h00;
      mreg[i] = 8'h00;
    end
    mst = 3'b000;
    bus.instr = '0;
    bus.instr_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 16'(bus.instr_ready), 16'd1);
    chk("rst_we",    16'(bus.rf_we),       16'd0);
    chk("rst_done",  16'(bus.done),        16'd0);
    chk("rst_st",    16'(bus.status),      16'd0);
    chk("rst_dataw", 16'(bus.rf_dataW),    16'd0);
    chk("rst_sela",  16'(bus.rf_selA),     16'd0);
    rst = 1'b0;
    @(negedge clk);

    // MOVI r2,#5A: WB in the cycle after the handshake
    send(movi(2'd2, 8'h5A), 1'b0, 1'b1);
    @(negedge clk);
    chk("movi_done",  16'(bus.done),     16'd1);
    chk("movi_we",    16'(bus.rf_we),    16'd1);
    chk("movi_sela",  16'(bus.rf_selA),  16'd2);
    chk("movi_dataw", 16'(bus.rf_dataW), 16'h5A);
    @(negedge clk);
    chk("movi_done_pulse", 16'(bus.done),        16'd0);
    chk("movi_ready_back", 16'(bus.instr_ready), 16'd1);

    // ADD r3,r0,r1 with r0=7F, r1=01
    send(movi(2'd0, 8'h7F), 1'b0, 1'b1);
    send(movi(2'd1, 8'h01), 1'b0, 1'b1);
    send(mk(2'b01, 2'd3, 2'd0, 2'd1), 1'b0, 1'b1);
    @(negedge clk);
    chk("add_read_sela", 16'(bus.rf_selA),     16'd0);
    chk("add_read_selb", 16'(bus.rf_selB),     16'd1);
    chk("add_read_rdy",  16'(bus.instr_ready), 16'd0);
    chk("add_read_done", 16'(bus.done),        16'd0);
    @(negedge clk);
    chk("add_exec_we",   16'(bus.rf_we),       16'd0);
    @(negedge clk);
    chk("add_wb_done",   16'(bus.done),        16'd1);
    chk("add_wb_sela",   16'(bus.rf_selA),     16'd3);
    chk("add_wb_dataw",  16'(bus.rf_dataW),    16'h80);
    chk("add_wb_st",     16'(bus.status),      ST_EN ? 16'b101 : 16'b000);

    // AND r1,r1,r1 then MVN r0,r1 with r1=F0
    send(movi(2'd1, 8'hF0), 1'b0, 1'b1);
    send(mk(2'b10, 2'd1, 2'd1, 2'd1), 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("and_dataw", 16'(bus.rf_dataW), 16'hF0);
    send(mk(2'b11, 2'd0, 2'd1, 2'd2), 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("mvn_dataw", 16'(bus.rf_dataW), 16'h0F);
    chk("mvn_v",     16'(bus.status[0]), 16'd0);

    // Back-to-back with instr_valid held high
    send(mk(2'b01, 2'd2, 2'd3, 2'd0), 1'b1, 1'b1);
    bus.instr = movi(2'd3, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_ready_low", 16'(bus.instr_ready), 16'd0);
    end
    send(movi(2'd3, 8'h00), 1'b1, 1'b1);
    bus.instr = mk(2'b01, 2'd0, 2'd3, 2'd3);
    @(negedge clk);
    chk("b2b_movi_ready_low", 16'(bus.instr_ready), 16'd0);
    send(mk(2'b01, 2'd0, 2'd3, 2'd3), 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("b2b_zero_st", 16'(bus.status), ST_EN ? 16'b010 : 16'b000);

    // Reset during EXEC of an ADD: write abandoned
    @(negedge clk);
    send(mk(2'b01, 2'd3, 2'd0, 2'd1), 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mst = 3'b000;
    chk("rstx_ready", 16'(bus.instr_ready), 16'd1);
    chk("rstx_we",    16'(bus.rf_we),       16'd0);
    chk("rstx_done",  16'(bus.done),        16'd0);
    chk("rstx_st",    16'(bus.status),      16'd0);
    repeat (3) @(negedge clk);
    chk("rstx_r3_kept", 16'(rf[3]), 16'(mreg[3]));

    // Recovery after mid-instruction reset
    send(mk(2'b01, 2'd1, 2'd2, 2'd2), 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    chk("rf_r1", 16'(rf[1]), 16'(mreg[1]));
    chk("rf_r2", 16'(rf[2]), 16'(mreg[2]));
    chk("sb_drained", 16'(sb.size()), 16'd0);
    chk("accepted", 16'(acc_seen), 16'(acc_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multicycle control-and-datapath stage that drives the 4x8 register file.
- Accepts one instruction per valid/ready handshake, then reads operands through the two read ports, computes the ALU result, and writes it back through the write port.
- The register file's write address is its port-A select, so this block time-multiplexes selA between source-read and write-back.
- Sits between the instruction source (testbench or switches) and the register file.

Parameters:
- DW, 8: datapath and register width. Must be >= 4.
- NREG_LOG2, 2: register address width. Fixed at 2 for this block.

Ports:
- clk  in  1: sole clock. All state updates on rising edge.
- rst  in  1: reset. One clock; reset is synchronous and active-high.
- instr  in  DW+4: instruction word.
  - op = [DW+3:DW+2], rd = [DW+1:DW].
  - imm = [DW-1:0].
  - rs1 = [DW-1:DW-2], rs2 = [DW-3:DW-4].
- instr_valid  in  1: instr is valid.
- instr_ready  out  1: block can accept an instruction.
- rf_we  out  1: register file write enable.
- rf_selA  out  2: register file port-A select; also the write address.
- rf_selB  out  2: register file port-B select.
- rf_dataW  out  DW: write data.
- rf_dataA  in  DW: port-A read data (combinational).
- rf_dataB  in  DW: port-B read data (combinational).
- done  out  1: one-cycle pulse in the write-back cycle.
- status  out  3: {N, Z, V} flags of the last ALU op.

Behaviour:
- Ops:
  - 00 MOVI: rd <= imm.
  - 01 ADD: rd <= rs1 + rs2, modulo 2^DW.
  - 10 AND: rd <= rs1 & rs2.
  - 11 MVN: rd <= ~rs1; rs2 is ignored.
- Registered state: FSM state, IR (instruction), A, B, C (DW each), status.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: instr_ready=1. On instr_valid, capture instr into IR.
    - MOVI: load C <= imm, go to WB.
    - Otherwise: go to READ.
  - READ: rf_selA=IR.rs1, rf_selB=IR.rs2. Capture A <= rf_dataA and B <= rf_dataB at the edge. Go to EXEC.
  - EXEC: C <= f(A,B). Update status. Go to WB.
  - WB: rf_selA=IR.rd, rf_we=1, rf_dataW=C, done=1. Go to IDLE.
- Outputs are decoded from state/IR only; no input-to-output combinational path. instr_ready is low outside IDLE.
- Unused select values: when not in READ or WB, rf_selA=IR.rd and rf_selB=IR.rs2. rf_dataW always equals C.
- Latency, with the handshake at edge k:
  - ALU op: WB occupies cycle k+3; write lands at edge k+3.
  - MOVI: WB occupies cycle k+1.
  - Throughput: one ALU op per 4 cycles, one MOVI per 2 cycles.
- Status (when enabled):
  - Updated only in EXEC; MOVI leaves status unchanged.
  - N = C[DW-1], Z = (C==0).
  - V = signed overflow for ADD; 0 for AND and MVN.
- Same-register cases: rd equal to rs1 or rs2 is legal. Operands are captured before write-back, so the result uses the old values.
- Reset:
  - rst asserted at any edge (including mid-instruction): state goes to IDLE; IR, A, B, C and status are cleared to 0.
  - In the cycle after the reset edge, rf_we=0 and done=0. An in-flight write is abandoned.
  - rst has priority over instr_valid.
- The register file's own reset is driven at top level from the same rst, inverted. This block does not drive it.

Optional Feature:
- Macro: EXEC_SEQUENCER_STATUS_EN.
- Defined: N, Z and V flags are implemented exactly as in Behaviour.
- Undefined: status is tied to 3'b000, no flag registers are built, and all other behaviour is identical.

Decomposition:
- Package exec_seq_pkg:
  - typedef enum state_t {IDLE, READ, EXEC, WB}.
  - typedef enum opcode_t {OP_MOVI, OP_ADD, OP_AND, OP_MVN}.
  - Field-position localparams for op, rd, rs1, rs2 and imm.
- Sub-module exec_alu: combinational.
  - Inputs: opcode, A, B.
  - Outputs: result, N, Z, V.
  - Instantiated once. FSM and registers stay in exec_sequencer.

Test Plan:
- Reset, then MOVI r2,#0x5A: WB occurs 1 cycle after the handshake, with rf_selA=2, rf_we=1, rf_dataW=0x5A, and a single done pulse.
- Preload r0=0x7F and r1=0x01, then ADD r3,r0,r1:
  - READ cycle shows selA=0, selB=1.
  - WB at k+3 writes 0x80 to r3, with status N=1, Z=0, V=1.
- Preload r1=0xF0, then AND r1,r1,r1 followed by MVN r0,r1: writes 0xF0 then 0x0F; for MVN, V=0.
- Hold instr_valid high for back-to-back instructions: instr_ready stays low in READ/EXEC/WB; exactly one instruction is accepted per IDLE visit; no instruction is lost or duplicated.
- Assert rst during EXEC of an ADD: next cycle is IDLE, rf_we never asserts, and status=0.
- Compile without EXEC_SEQUENCER_STATUS_EN and rerun scenario 2: identical writes, status=000.
